// File: rtl/main_memory_responder.sv
// Backing-store responder below the L2. It accepts line-fill reads and single-word
// writes, waits a fixed access latency, then returns a beat burst or a write ack.
module main_memory_responder #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 11,
    parameter int BEATS      = 4,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_ready,
    output logic                  mem_rvalid,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_rlast,
    output logic                  mem_wack,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(BEATS - 1);
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [LAT_W-1:0]      LAT_LOAD  = LAT_W'(LATENCY - 1);
    localparam logic [15:0]           CNT_MAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        WACK
    } state_t;

    state_t                r_state;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [LAT_W-1:0]      r_lat;
    logic [BEAT_W-1:0]     r_beat;
    logic                  r_ready;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rlast;
    logic                  r_wack;
    logic [15:0]           r_rd_count;
    logic [15:0]           r_wr_count;

    // A word never written reads back as its own address, which gives the
    // time-0 contents without needing a preloaded array.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      r_written = '0;

    logic                  w_accept;
    logic [BEAT_W-1:0]     w_next_beat;

    assign w_accept    = mem_req & r_ready & ~rst;
    assign w_next_beat = r_beat + BEAT_W'(1);

    function automatic logic [DATA_WIDTH-1:0] read_word(input logic [ADDR_WIDTH-1:0] a);
        return r_written[a] ? r_mem[a] : DATA_WIDTH'(a);
    endfunction

    // NOTE: the storage array has no reset; rst must never disturb committed data.
    always_ff @(posedge clk) begin
        if (w_accept && mem_we) begin
            r_mem[mem_addr]     <= mem_wdata;
            r_written[mem_addr] <= 1'b1;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_base     <= '0;
            r_lat      <= '0;
            r_beat     <= '0;
            r_ready    <= 1'b1;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rlast    <= 1'b0;
            r_wack     <= 1'b0;
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= WAIT;
                        r_ready <= 1'b0;
                        r_we    <= mem_we;
                        r_base  <= mem_addr & ~LINE_MASK;
                        r_lat   <= LAT_LOAD;
                        if (mem_we) begin
                            if (r_wr_count != CNT_MAX) r_wr_count <= r_wr_count + 16'd1;
                        end else begin
                            if (r_rd_count != CNT_MAX) r_rd_count <= r_rd_count + 16'd1;
                        end
                    end
                end
                WAIT: begin
                    if (r_lat == '0) begin
                        if (r_we) begin
                            r_state <= WACK;
                            r_wack  <= 1'b1;
                        end else begin
                            r_state  <= BURST;
                            r_beat   <= '0;
                            r_rvalid <= 1'b1;
                            r_rdata  <= read_word(r_base);
                            r_rlast  <= (BEATS == 1);
                        end
                    end else begin
                        r_lat <= r_lat - LAT_W'(1);
                    end
                end
                BURST: begin
                    if (r_rlast) begin
                        r_state  <= IDLE;
                        r_ready  <= 1'b1;
                        r_rvalid <= 1'b0;
                        r_rlast  <= 1'b0;
                        r_rdata  <= '0;
                    end else begin
                        // Beat index is ORed into the base so a fill never carries out of its line.
                        r_beat  <= w_next_beat;
                        r_rdata <= read_word(r_base | ADDR_WIDTH'(w_next_beat));
                        r_rlast <= (w_next_beat == LAST_BEAT);
                    end
                end
                WACK: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_wack  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign mem_ready  = r_ready;
    assign mem_rvalid = r_rvalid;
    assign mem_rdata  = r_rdata;
    assign mem_rlast  = r_rlast;
    assign mem_wack   = r_wack;
    assign rd_count   = r_rd_count;
    assign wr_count   = r_wr_count;

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder: directed vector table, multi-cycle
// corner sequences, and random traffic checked against an array model of memory.
module tb_main_memory_responder;
    localparam int AW      = 11;
    localparam int DW      = 11;
    localparam int BEATS   = 4;
    localparam int LATENCY = 4;
    localparam int DEPTH   = 2 ** AW;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          mem_req   = 1'b0;
    logic          mem_we    = 1'b0;
    logic [AW-1:0] mem_addr  = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          mem_rlast;
    logic          mem_wack;
    logic [15:0]   rd_count;
    logic [15:0]   wr_count;

    int errors = 0;
    int checks = 0;
    int exp_rd = 0;
    int exp_wr = 0;
    int model_mem [DEPTH];
    int got [BEATS];

    typedef struct {
        bit we;
        int addr;
        int wdata;
        int e0;
        int e1;
        int e2;
        int e3;
    } vec_t;

    vec_t vecs [6];

    main_memory_responder #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .BEATS     (BEATS),
        .LATENCY   (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .mem_rlast (mem_rlast),
        .mem_wack  (mem_wack),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  32'(mem_ready),  32'd1);
        check({tag, "_rvalid"}, 32'(mem_rvalid), 32'd0);
        check({tag, "_rdata"},  32'(mem_rdata),  32'd0);
        check({tag, "_rlast"},  32'(mem_rlast),  32'd0);
        check({tag, "_wack"},   32'(mem_wack),   32'd0);
        check({tag, "_rdcnt"},  32'(rd_count),   32'd0);
        check({tag, "_wrcnt"},  32'(wr_count),   32'd0);
    endtask

    // Presents a request at a falling edge, waits for ready, and returns just after the accepting edge.
    task automatic issue(input bit we, input int addr, input int wdata);
        int guard = 0;
        @(negedge clk);
        mem_req   = 1'b1;
        mem_we    = we;
        mem_addr  = AW'(addr);
        mem_wdata = DW'(wdata);
        while (!mem_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_wait", 32'(guard < 50), 32'd1);
        @(posedge clk);
        if (we) begin
            exp_wr++;
            model_mem[addr % DEPTH] = wdata % (2 ** DW);
        end else begin
            exp_rd++;
        end
        #1;
        mem_req = 1'b0;
    endtask

    // Follows an accepted request from the acceptance edge to the following idle cycle.
    task automatic collect(input bit we);
        int  lat  = 0;
        bit  seen = 1'b0;
        for (int e = 1; e <= LATENCY + 8 && !seen; e++) begin
            @(posedge clk);
            #1;
            if (we ? mem_wack : mem_rvalid) begin
                seen = 1'b1;
                lat  = e;
            end else begin
                check("busy_ready", 32'(mem_ready), 32'd0);
            end
        end
        check(we ? "wack_latency" : "rvalid_latency", 32'(lat), 32'(LATENCY));
        if (!we) begin
            for (int b = 0; b < BEATS; b++) begin
                if (b > 0) begin
                    @(posedge clk);
                    #1;
                end
                got[b] = int'(mem_rdata);
                check("beat_rvalid", 32'(mem_rvalid), 32'd1);
                check("beat_rlast",  32'(mem_rlast),  32'(b == BEATS - 1));
            end
        end
        @(posedge clk);
        #1;
        check("after_ready",  32'(mem_ready),  32'd1);
        check("after_rvalid", 32'(mem_rvalid), 32'd0);
        check("after_wack",   32'(mem_wack),   32'd0);
        check("rd_count",     32'(rd_count),   32'(exp_rd));
        check("wr_count",     32'(wr_count),   32'(exp_wr));
    endtask

    task automatic txn(input bit we, input int addr, input int wdata);
        issue(we, addr, wdata);
        collect(we);
    endtask

    initial begin
        int exp_beats [BEATS];
        int stray;

        for (int i = 0; i < DEPTH; i++) model_mem[i] = i % (2 ** DW);

        vecs[0] = '{1'b0, 'h123, 0,     'h120, 'h121, 'h122, 'h123};
        vecs[1] = '{1'b1, 'h2A3, 'h055, 0,     0,     0,     0};
        vecs[2] = '{1'b0, 'h2A0, 0,     'h2A0, 'h2A1, 'h2A2, 'h055};
        vecs[3] = '{1'b0, 'h7FE, 0,     'h7FC, 'h7FD, 'h7FE, 'h7FF};
        vecs[4] = '{1'b1, 'h000, 'h7AB, 0,     0,     0,     0};
        vecs[5] = '{1'b0, 'h003, 0,     'h7AB, 'h001, 'h002, 'h003};

        // Power-on reset values.
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            if (!vecs[i].we) begin
                exp_beats = '{vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3};
                for (int b = 0; b < BEATS; b++)
                    check($sformatf("vec%0d_beat%0d", i, b), 32'(got[b]), 32'(exp_beats[b]));
            end
        end

        // Busy rejection: request held with a new address throughout a burst.
        @(negedge clk);
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = AW'('h100);
        @(posedge clk);
        exp_rd++;
        #1;
        mem_addr = AW'('h345);
        for (int e = 1; e <= LATENCY + BEATS; e++) begin
            @(posedge clk);
            #1;
            if (e < LATENCY + BEATS) begin
                check("held_ready_low", 32'(mem_ready), 32'd0);
            end else begin
                check("held_ready_high", 32'(mem_ready), 32'd1);
                check("held_rd_count",   32'(rd_count),  32'(exp_rd));
            end
            if (e == LATENCY + BEATS - 1) check("held_rlast", 32'(mem_rlast), 32'd1);
        end
        @(posedge clk);
        exp_rd++;
        #1;
        mem_req = 1'b0;
        collect(1'b0);
        for (int b = 0; b < BEATS; b++)
            check($sformatf("held_beat%0d", b), 32'(got[b]), 32'('h344 + b));

        // Reset asserted mid-burst.
        issue(1'b0, 'h010, 0);
        repeat (LATENCY + 1) @(posedge clk);
        #2;
        check("midburst_rvalid", 32'(mem_rvalid), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midburst");
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        exp_rd = 0;
        exp_wr = 0;
        stray  = 0;
        repeat (LATENCY + BEATS + 2) begin
            @(posedge clk);
            #1;
            if (mem_rvalid || mem_wack || !mem_ready) stray++;
        end
        check("midburst_stray", 32'(stray), 32'd0);

        // Reset in WAIT after a write was accepted: no ack, but the data stays committed.
        issue(1'b1, 'h200, 'h011);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midwait_wack", 32'(mem_wack), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        exp_rd = 0;
        exp_wr = 0;
        stray  = 0;
        repeat (LATENCY + 4) begin
            @(posedge clk);
            #1;
            if (mem_wack || mem_rvalid) stray++;
        end
        check("midwait_stray", 32'(stray), 32'd0);
        txn(1'b0, 'h200, 0);
        check("midwait_beat0", 32'(got[0]), 32'h011);
        check("midwait_beat1", 32'(got[1]), 32'h201);

        // Random traffic against the array model.
        for (int n = 0; n < 60; n++) begin
            bit we;
            int addr;
            int wdata;
            int base;
            we    = 1'($urandom_range(0, 1));
            addr  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 31))
                                                : int'($urandom_range(0, DEPTH - 1));
            wdata = int'($urandom_range(0, (2 ** DW) - 1));
            txn(we, addr, wdata);
            if (!we) begin
                base = (addr / BEATS) * BEATS;
                for (int b = 0; b < BEATS; b++)
                    check($sformatf("rnd%0d_beat%0d", n, b), 32'(got[b]), 32'(model_mem[base + b]));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
